lif_neuron_array: RTL
=====================

Name: lif_neuron_array

Overview:
Parametrised array of N leaky integrate-and-fire neurons sharing one clock, with runtime-programmable threshold, leak, synaptic weight, refractory period and post-spike reset mode. It generalises the single fixed LIF neuron behind our TT top level. Each neuron integrates its own input spike line and emits registered one-cycle output spikes. A shared saturating counter and a membrane-potential readout mux support bring-up and debug.

Parameters:
N_NEURONS, 4, number of independent neurons/channels (1..16)
V_WIDTH, 8, membrane potential width, unsigned
W_WIDTH, 4, synaptic weight width, unsigned (W_WIDTH <= V_WIDTH)
R_WIDTH, 4, refractory counter width
C_WIDTH, 16, output spike counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
ena  in  1  global enable; 0 freezes all state
spike_in  in  N_NEURONS  input spike per neuron, sampled each enabled cycle
weight  in  W_WIDTH  amount added to v on an input spike (shared)
leak  in  V_WIDTH  amount subtracted from v every enabled cycle (shared)
threshold  in  V_WIDTH  firing threshold (shared)
refrac  in  R_WIDTH  refractory length in enabled cycles after a spike
reset_mode  in  1  0 = reset v to 0 on fire, 1 = subtract threshold
v_sel  in  clog2(N_NEURONS) (min 1)  neuron selected for v_out
spike_out  out  N_NEURONS  registered output spikes, one-cycle pulses
v_out  out  V_WIDTH  membrane potential of neuron v_sel (combinational mux of registered v)
spike_cnt  out  C_WIDTH  total output spikes since reset, saturating

Behaviour:
- Clock is clk; reset is synchronous, active-low (rst_n). While rst_n=0 at a clk edge: all v=0, all refractory counters=0, spike_out=0, spike_cnt=0. Reset overrides ena and any in-progress refractory period.
- ena=0: v, refractory counters, spike_cnt held; spike_out forced to 0 on that edge.
- Per neuron i, each enabled edge, refractory counter r_i:
  - r_i>0: r_i <= r_i-1; v_i held at current value; spike_in[i] ignored; spike_out[i] <= 0.
  - r_i=0: compute in V_WIDTH+1 bits: l = (v_i >= leak) ? v_i-leak : 0 (floor at 0); s = l + (spike_in[i] ? zero-extended weight : 0); clamp s to 2^V_WIDTH-1.
    - s >= threshold: spike_out[i] <= 1; r_i <= refrac; v_i <= (reset_mode ? s-threshold : 0).
    - else: spike_out[i] <= 0; v_i <= s.
- Order fixed: leak, then integrate, then compare. threshold=0 means fire on every non-refractory enabled cycle.
- Latency: spike_in sampled at edge k produces spike_out at edge k (visible during cycle k+1); exactly one cycle high per fire.
- refrac=0: neuron may fire on consecutive enabled cycles. Changing refrac mid-period does not affect a running counter.
- spike_cnt <= spike_cnt + popcount(spike_out next value), saturating at 2^C_WIDTH-1; no wrap.
- Config inputs are sampled live each cycle and are not latched.
- v_sel >= N_NEURONS: v_out = 0.

Test Plan:
- N=4,V=8,W=4; thr=20, leak=1, weight=5, refrac=2, mode=0, spike_in[0]=1 constant -> v0 goes 5,9,13,17 then fires on the 5th enabled edge; spike_out[0] pulses one cycle, v0=0, 2 refractory cycles, then repeats with period 7; other neurons stay 0.
- thr=20, leak=0, weight=15, refrac=0, mode=1, spike_in[1]=1 -> v1 goes 15, fire(10), fire(5), fire(0), 15; spike_out[1] high on edges 2, 3 and 4; spike_cnt=3.
- Preload v2=5 via weight=5 with one input pulse (thr=255), then leak=3 with no input -> v2 goes 2, 0, 0 (floors, no underflow).
- thr=255, leak=0, weight=15, spike_in[3]=1 for 20 cycles -> v3 reaches 255 on edge 17, fires, and never exceeds 255 (clamp checked with a 250+15 step).
- ena=0 for 3 cycles mid-integration -> v and r frozen, spike_out=0; resumes exactly where it stopped. rst_n=0 one edge during refractory -> all v=0, r=0, spike_cnt=0; the neuron integrates immediately after.
- All 4 inputs=1 with thr=weight=5, leak=0, refrac=0 -> spike_out=4'b1111 every cycle, spike_cnt increments by 4 per cycle; with C_WIDTH=4 it holds at 15.

Source files
------------

// File: rtl/lif_neuron_array_if.sv
// Configuration, spike and debug-readout bundle for lif_neuron_array.
// master drives stimulus and configuration; slave is the neuron array.
interface lif_neuron_array_if #(
  parameter int N_NEURONS = 4,
  parameter int V_WIDTH   = 8,
  parameter int W_WIDTH   = 4,
  parameter int R_WIDTH   = 4,
  parameter int C_WIDTH   = 16
);
  localparam int SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic                 ena;
  logic [N_NEURONS-1:0] spike_in;
  logic [W_WIDTH-1:0]   weight;
  logic [V_WIDTH-1:0]   leak;
  logic [V_WIDTH-1:0]   threshold;
  logic [R_WIDTH-1:0]   refrac;
  logic                 reset_mode;
  logic [SEL_W-1:0]     v_sel;
  logic [N_NEURONS-1:0] spike_out;
  logic [V_WIDTH-1:0]   v_out;
  logic [C_WIDTH-1:0]   spike_cnt;

  modport master (
    output ena, spike_in, weight, leak, threshold, refrac, reset_mode, v_sel,
    input  spike_out, v_out, spike_cnt
  );

  modport slave (
    input  ena, spike_in, weight, leak, threshold, refrac, reset_mode, v_sel,
    output spike_out, v_out, spike_cnt
  );
endinterface

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons with shared runtime configuration,
// a saturating output-spike counter and a membrane-potential readout mux.
module lif_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int V_WIDTH   = 8,
  parameter int W_WIDTH   = 4,
  parameter int R_WIDTH   = 4,
  parameter int C_WIDTH   = 16
) (
  input logic              clk,
  input logic              rst_n,
  lif_neuron_array_if.slave bus
);
  localparam int SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int VS_W  = V_WIDTH + 1;
  localparam int SUM_W = C_WIDTH + 5;
  localparam logic [VS_W-1:0]  V_MAX = {1'b0, {V_WIDTH{1'b1}}};
  localparam logic [SUM_W-1:0] C_MAX = SUM_W'({C_WIDTH{1'b1}});

  function automatic logic [V_WIDTH-1:0] leak_floor(input logic [V_WIDTH-1:0] v,
                                                    input logic [V_WIDTH-1:0] amt);
    return (v >= amt) ? v - amt : '0;
  endfunction

  function automatic logic [V_WIDTH-1:0] clamp_v(input logic [VS_W-1:0] s);
    return (s > V_MAX) ? V_MAX[V_WIDTH-1:0] : s[V_WIDTH-1:0];
  endfunction

  function automatic logic [C_WIDTH-1:0] sat_cnt(input logic [SUM_W-1:0] s);
    return (s > C_MAX) ? C_MAX[C_WIDTH-1:0] : s[C_WIDTH-1:0];
  endfunction

  logic [V_WIDTH-1:0]   v_p0 [N_NEURONS];
  logic [R_WIDTH-1:0]   r_p0 [N_NEURONS];
  logic [N_NEURONS-1:0] spike_p0;
  logic [C_WIDTH-1:0]   cnt_p0;

  logic [V_WIDTH-1:0]   v_nxt [N_NEURONS];
  logic [R_WIDTH-1:0]   r_nxt [N_NEURONS];
  logic [N_NEURONS-1:0] fire_nxt;
  logic [V_WIDTH-1:0]   s_c;
  logic [SUM_W-1:0]     pop_c;
  logic [C_WIDTH-1:0]   cnt_nxt;

  // Stage 0: leak, integrate, clamp, compare for every neuron
  always_comb begin
    pop_c = '0;
    s_c   = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      v_nxt[i]    = v_p0[i];
      r_nxt[i]    = r_p0[i];
      fire_nxt[i] = 1'b0;
      if (r_p0[i] != '0) begin
        r_nxt[i] = r_p0[i] - R_WIDTH'(1);
      end else begin
        s_c = clamp_v(VS_W'(leak_floor(v_p0[i], bus.leak)) +
                      (bus.spike_in[i] ? VS_W'(bus.weight) : VS_W'(0)));
        if (s_c >= bus.threshold) begin
          fire_nxt[i] = 1'b1;
          r_nxt[i]    = bus.refrac;
          v_nxt[i]    = bus.reset_mode ? s_c - bus.threshold : '0;
        end else begin
          v_nxt[i] = s_c;
        end
      end
      pop_c = pop_c + SUM_W'(fire_nxt[i]);
    end
    cnt_nxt = sat_cnt(SUM_W'(cnt_p0) + pop_c);
  end

  // Stage 0 -> registered state and output spikes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_p0[i] <= '0;
        r_p0[i] <= '0;
      end
      spike_p0 <= '0;
      cnt_p0   <= '0;
    end else if (bus.ena) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_p0[i] <= v_nxt[i];
        r_p0[i] <= r_nxt[i];
      end
      spike_p0 <= fire_nxt;
      cnt_p0   <= cnt_nxt;
    end else begin
      spike_p0 <= '0;
    end
  end

  always_comb begin
    bus.v_out = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (bus.v_sel == SEL_W'(i)) bus.v_out = v_p0[i];
    end
  end

  assign bus.spike_out = spike_p0;
  assign bus.spike_cnt = cnt_p0;
endmodule
